// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing the data port of the core RAM between the LSU (master 0)
// and the debug/loader bus (master 1), with single-cycle responses and range checking.
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req_i,
    output logic                  p0_gnt_o,
    input  logic [31:0]           p0_addr_i,
    input  logic                  p0_we_i,
    input  logic [3:0]            p0_be_i,
    input  logic [31:0]           p0_wdata_i,
    output logic                  p0_rvalid_o,
    output logic                  p0_err_o,
    output logic [31:0]           p0_rdata_o,
    input  logic                  p1_req_i,
    output logic                  p1_gnt_o,
    input  logic [31:0]           p1_addr_i,
    input  logic                  p1_we_i,
    input  logic [3:0]            p1_be_i,
    input  logic [31:0]           p1_wdata_i,
    output logic                  p1_rvalid_o,
    output logic                  p1_err_o,
    output logic [31:0]           p1_rdata_o,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i
);

    logic        last_q, last_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_port_q, resp_port_d;
    logic        resp_err_q, resp_err_d;
    logic        resp_we_q, resp_we_d;

    logic        gnt0_s, gnt1_s, any_gnt_s, sel_s, in_range_s;
    logic [31:0] sel_addr_s, sel_wdata_s, resp_data_s;
    logic        sel_we_s;
    logic [3:0]  sel_be_s;

    // Grant selection: last_q names the previous winner, so the other master wins a tie.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!rst_n) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (p0_req_i && p1_req_i) begin
            if (last_q) begin
                gnt0_s = 1'b1;
            end else begin
                gnt1_s = 1'b1;
            end
        end else if (p0_req_i) begin
            gnt0_s = 1'b1;
        end else if (p1_req_i) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign any_gnt_s = gnt0_s | gnt1_s;
    assign sel_s     = gnt1_s;
    assign p0_gnt_o  = gnt0_s;
    assign p1_gnt_o  = gnt1_s;

    // Request mux for the granted master.
    always_comb begin
        sel_addr_s  = p0_addr_i;
        sel_we_s    = p0_we_i;
        sel_be_s    = p0_be_i;
        sel_wdata_s = p0_wdata_i;
        if (sel_s) begin
            sel_addr_s  = p1_addr_i;
            sel_we_s    = p1_we_i;
            sel_be_s    = p1_be_i;
            sel_wdata_s = p1_wdata_i;
        end else begin
            sel_addr_s  = p0_addr_i;
            sel_we_s    = p0_we_i;
            sel_be_s    = p0_be_i;
            sel_wdata_s = p0_wdata_i;
        end
    end

    assign in_range_s = (sel_addr_s[31:ADDR_WIDTH] == {(32-ADDR_WIDTH){1'b0}});

    // RAM port drive; out-of-range accesses are granted but never reach the RAM.
    always_comb begin
        ram_en_o    = 1'b0;
        ram_addr_o  = {ADDR_WIDTH{1'b0}};
        ram_we_o    = 1'b0;
        ram_be_o    = 4'b0000;
        ram_wdata_o = 32'h0000_0000;
        if (any_gnt_s && in_range_s) begin
            ram_en_o    = 1'b1;
            ram_addr_o  = {sel_addr_s[ADDR_WIDTH-1:2], 2'b00};
            ram_we_o    = sel_we_s;
            ram_be_o    = sel_be_s;
            ram_wdata_o = sel_wdata_s;
        end else begin
            ram_en_o    = 1'b0;
        end
    end

    // Next state for arbitration history and the one-deep response register.
    always_comb begin
        last_d       = last_q;
        resp_valid_d = any_gnt_s;
        resp_port_d  = resp_port_q;
        resp_err_d   = resp_err_q;
        resp_we_d    = resp_we_q;
        if (any_gnt_s) begin
            last_d      = sel_s;
            resp_port_d = sel_s;
            resp_err_d  = ~in_range_s;
            resp_we_d   = sel_we_s;
        end else begin
            last_d      = last_q;
        end
    end

    // State registers; reset drops any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q       <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_port_q  <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_we_q    <= 1'b0;
        end else begin
            last_q       <= last_d;
            resp_valid_q <= resp_valid_d;
            resp_port_q  <= resp_port_d;
            resp_err_q   <= resp_err_d;
            resp_we_q    <= resp_we_d;
        end
    end

    // Response routing; data is only passed through for successful reads.
    always_comb begin
        p0_rvalid_o = 1'b0;
        p1_rvalid_o = 1'b0;
        resp_data_s = 32'h0000_0000;
        if (rst_n && resp_valid_q) begin
            p0_rvalid_o = ~resp_port_q;
            p1_rvalid_o = resp_port_q;
            if (resp_err_q || resp_we_q) begin
                resp_data_s = 32'h0000_0000;
            end else begin
                resp_data_s = ram_rdata_i;
            end
        end else begin
            p0_rvalid_o = 1'b0;
            p1_rvalid_o = 1'b0;
        end
    end

    assign p0_err_o   = p0_rvalid_o & resp_err_q;
    assign p1_err_o   = p1_rvalid_o & resp_err_q;
    assign p0_rdata_o = p0_rvalid_o ? resp_data_s : 32'h0000_0000;
    assign p1_rdata_o = p1_rvalid_o ? resp_data_s : 32'h0000_0000;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: behavioural RAM, shadow memory model and a response scoreboard.
module tb_dmem_port_arbiter;

    localparam int AW = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req_i, p0_gnt_o, p0_we_i, p0_rvalid_o, p0_err_o;
    logic [31:0] p0_addr_i, p0_wdata_i, p0_rdata_o;
    logic [3:0]  p0_be_i;
    logic        p1_req_i, p1_gnt_o, p1_we_i, p1_rvalid_o, p1_err_o;
    logic [31:0] p1_addr_i, p1_wdata_i, p1_rdata_o;
    logic [3:0]  p1_be_i;
    logic        ram_en_o, ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i = 32'h0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          due;
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem    [0:1023];
    logic [31:0] shadow [0:1023];

    dmem_port_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_i(p0_req_i), .p0_gnt_o(p0_gnt_o), .p0_addr_i(p0_addr_i), .p0_we_i(p0_we_i),
        .p0_be_i(p0_be_i), .p0_wdata_i(p0_wdata_i), .p0_rvalid_o(p0_rvalid_o),
        .p0_err_o(p0_err_o), .p0_rdata_o(p0_rdata_o),
        .p1_req_i(p1_req_i), .p1_gnt_o(p1_gnt_o), .p1_addr_i(p1_addr_i), .p1_we_i(p1_we_i),
        .p1_be_i(p1_be_i), .p1_wdata_i(p1_wdata_i), .p1_rvalid_o(p1_rvalid_o),
        .p1_err_o(p1_err_o), .p1_rdata_o(p1_rdata_o),
        .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o),
        .ram_be_o(ram_be_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM: writes commit at the edge ending the write cycle, reads return next cycle.
    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be_o[b]) mem[ram_addr_o[11:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
                end
            end else begin
                ram_rdata_i <= mem[ram_addr_o[11:2]];
            end
        end
    end

    task automatic set_p0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd);
        p0_req_i = req; p0_we_i = we; p0_addr_i = addr; p0_be_i = be; p0_wdata_i = wd;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd);
        p1_req_i = req; p1_we_i = we; p1_addr_i = addr; p1_be_i = be; p1_wdata_i = wd;
    endtask

    // Model of one granted access: updates the shadow and queues the expected response.
    task automatic push_exp(input logic port, input logic we, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wd);
        exp_t e;
        e.due  = cyc + 1;
        e.port = port;
        e.err  = (addr[31:AW] != 12'h000);
        e.rdata = 32'h0;
        if (!e.err) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) shadow[addr[11:2]][8*b +: 8] = wd[8*b +: 8];
                end
            end else begin
                e.rdata = shadow[addr[11:2]];
            end
        end
        sb.push_back(e);
    endtask

    // Response monitor: pops the scoreboard in the due cycle, otherwise expects silence.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                total++;
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    if (p0_rvalid_o !== ~e.port || p1_rvalid_o !== e.port ||
                        (e.port ? p1_err_o : p0_err_o) !== e.err ||
                        (e.port ? p1_rdata_o : p0_rdata_o) !== e.rdata ||
                        (e.port ? p0_rdata_o : p1_rdata_o) !== 32'h0 ||
                        (e.port ? p0_err_o : p1_err_o) !== 1'b0) begin
                        bad++;
                        $display("FAIL resp cyc=%0d: got rv=%b%b err=%b%b rd0=%h rd1=%h, want port=%0d err=%b rdata=%h",
                                 cyc, p1_rvalid_o, p0_rvalid_o, p1_err_o, p0_err_o, p0_rdata_o, p1_rdata_o,
                                 e.port, e.err, e.rdata);
                    end
                end else if (sb.size() > 0 && sb[0].due < cyc) begin
                    e = sb.pop_front();
                    bad++;
                    $display("FAIL resp_missing: got nothing at cyc=%0d, want response due cyc=%0d", cyc, e.due);
                end else if (p0_rvalid_o !== 1'b0 || p1_rvalid_o !== 1'b0) begin
                    bad++;
                    $display("FAIL spurious_rvalid cyc=%0d: got rv1=%b rv0=%b, want 00", cyc, p1_rvalid_o, p0_rvalid_o);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        set_p0(1'b1, 1'b1, 32'h100, 4'hF, 32'h1234_5678);
        set_p1(1'b1, 1'b0, 32'h104, 4'hF, 32'h0);
        repeat (2) @(negedge clk);
        total++;
        if ({p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, ram_en_o, ram_we_o} !== 6'b0 ||
            ram_be_o !== 4'h0 || ram_wdata_o !== 32'h0 || ram_addr_o !== 20'h0 ||
            p0_rdata_o !== 32'h0 || p1_rdata_o !== 32'h0 || p0_err_o !== 1'b0 || p1_err_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got gnt=%b%b en=%b we=%b be=%h, want all zero",
                     p1_gnt_o, p0_gnt_o, ram_en_o, ram_we_o, ram_be_o);
        end
        set_p0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_p1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        @(posedge clk); #1;
        set_p0(1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
        @(negedge clk);
        total++;
        if (p0_gnt_o !== 1'b1 || p1_gnt_o !== 1'b0 || ram_en_o !== 1'b1 || ram_addr_o !== 20'h00100 || ram_we_o !== 1'b0) begin
            bad++;
            $display("FAIL single_read_gnt: got gnt=%b%b en=%b addr=%h, want gnt=01 en=1 addr=00100",
                     p1_gnt_o, p0_gnt_o, ram_en_o, ram_addr_o);
        end
        push_exp(1'b0, 1'b0, 32'h100, 4'hF, 32'h0);
        total++;
        if (sb[sb.size()-1].rdata !== 32'h4433_2211) begin
            bad++;
            $display("FAIL preload_model: got %h, want 44332211", sb[sb.size()-1].rdata);
        end
        @(posedge clk); #1;
        set_p0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_byte_write();
        @(posedge clk); #1;
        set_p1(1'b1, 1'b1, 32'h202, 4'b0100, 32'h00AB_0000);
        @(negedge clk);
        total++;
        if (p1_gnt_o !== 1'b1 || p0_gnt_o !== 1'b0 || ram_addr_o !== 20'h00200 || ram_we_o !== 1'b1 ||
            ram_be_o !== 4'b0100 || ram_wdata_o !== 32'h00AB_0000) begin
            bad++;
            $display("FAIL byte_write_ram: got gnt=%b%b addr=%h we=%b be=%b wd=%h, want gnt=10 addr=00200 we=1 be=0100 wd=00ab0000",
                     p1_gnt_o, p0_gnt_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o);
        end
        push_exp(1'b1, 1'b1, 32'h202, 4'b0100, 32'h00AB_0000);
        @(posedge clk); #1;
        set_p1(1'b1, 1'b0, 32'h200, 4'hF, 32'h0);
        @(negedge clk);
        total++;
        if (p1_gnt_o !== 1'b1 || ram_we_o !== 1'b0) begin
            bad++;
            $display("FAIL byte_read_gnt: got gnt1=%b we=%b, want 1 0", p1_gnt_o, ram_we_o);
        end
        push_exp(1'b1, 1'b0, 32'h200, 4'hF, 32'h0);
        @(posedge clk); #1;
        set_p1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_contention();
        logic [31:0] a0, a1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            a0 = 32'h300 + 32'(8 * i);
            a1 = 32'h304 + 32'(8 * i);
            set_p0(1'b1, 1'b0, a0, 4'hF, 32'h0);
            set_p1(1'b1, 1'b0, a1, 4'hF, 32'h0);
            @(negedge clk);
            total++;
            if (p0_gnt_o !== ((i % 2) == 0) || p1_gnt_o !== ((i % 2) == 1) ||
                ram_addr_o !== (((i % 2) == 0) ? a0[AW-1:0] : a1[AW-1:0])) begin
                bad++;
                $display("FAIL contention_gnt[%0d]: got gnt=%b%b addr=%h, want p%0d", i, p1_gnt_o, p0_gnt_o, ram_addr_o, i % 2);
            end
            if ((i % 2) == 0) push_exp(1'b0, 1'b0, a0, 4'hF, 32'h0);
            else              push_exp(1'b1, 1'b0, a1, 4'hF, 32'h0);
        end
        @(posedge clk); #1;
        set_p0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_p1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_out_of_range();
        @(posedge clk); #1;
        set_p0(1'b1, 1'b1, 32'h0010_0000, 4'hF, 32'hCAFE_F00D);
        @(negedge clk);
        total++;
        if (p0_gnt_o !== 1'b1 || ram_en_o !== 1'b0 || ram_we_o !== 1'b0) begin
            bad++;
            $display("FAIL oor_write: got gnt0=%b en=%b we=%b, want 1 0 0", p0_gnt_o, ram_en_o, ram_we_o);
        end
        push_exp(1'b0, 1'b1, 32'h0010_0000, 4'hF, 32'hCAFE_F00D);
        @(posedge clk); #1;
        set_p0(1'b1, 1'b0, 32'h0010_0000, 4'hF, 32'h0);
        @(negedge clk);
        total++;
        if (p0_gnt_o !== 1'b1 || ram_en_o !== 1'b0) begin
            bad++;
            $display("FAIL oor_read: got gnt0=%b en=%b, want 1 0", p0_gnt_o, ram_en_o);
        end
        push_exp(1'b0, 1'b0, 32'h0010_0000, 4'hF, 32'h0);
        @(posedge clk); #1;
        set_p0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        set_p0(1'b1, 1'b1, 32'h40, 4'hF, 32'hDEAD_BEEF);
        @(negedge clk);
        push_exp(1'b0, 1'b1, 32'h40, 4'hF, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        set_p0(1'b1, 1'b0, 32'h43, 4'hF, 32'h0);
        @(negedge clk);
        total++;
        if (p0_gnt_o !== 1'b1 || ram_addr_o !== 20'h00040) begin
            bad++;
            $display("FAIL b2b_read_addr: got gnt0=%b addr=%h, want 1 00040", p0_gnt_o, ram_addr_o);
        end
        push_exp(1'b0, 1'b0, 32'h40, 4'hF, 32'h0);
        total++;
        if (sb[sb.size()-1].rdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL b2b_model: got %h, want deadbeef", sb[sb.size()-1].rdata);
        end
        @(posedge clk); #1;
        set_p0(1'b0, 1'b1, 32'h40, 4'hF, 32'h5555_5555);
        @(negedge clk);
        total++;
        if (p0_gnt_o !== 1'b0 || ram_en_o !== 1'b0 || ram_we_o !== 1'b0 || ram_be_o !== 4'h0 || ram_wdata_o !== 32'h0) begin
            bad++;
            $display("FAIL idle_ram: got gnt0=%b en=%b we=%b be=%h wd=%h, want all zero",
                     p0_gnt_o, ram_en_o, ram_we_o, ram_be_o, ram_wdata_o);
        end
    endtask

    task automatic test_reset_mid_op();
        @(posedge clk); #1;
        set_p1(1'b1, 1'b0, 32'h104, 4'hF, 32'h0);
        @(negedge clk);
        total++;
        if (p1_gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL midrst_gnt: got gnt1=%b, want 1", p1_gnt_o);
        end
        #2;
        rst_n = 1'b0;
        set_p1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (2) begin
            @(negedge clk);
            total++;
            if (p1_rvalid_o !== 1'b0 || p0_rvalid_o !== 1'b0 || p1_rdata_o !== 32'h0 || p1_gnt_o !== 1'b0) begin
                bad++;
                $display("FAIL midrst_held: got rv1=%b rv0=%b rd1=%h gnt1=%b, want zeros", p1_rvalid_o, p0_rvalid_o, p1_rdata_o, p1_gnt_o);
            end
        end
        @(posedge clk); #1;
        set_p0(1'b1, 1'b0, 32'h108, 4'hF, 32'h0);
        set_p1(1'b1, 1'b0, 32'h10C, 4'hF, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (p0_gnt_o !== 1'b1 || p1_gnt_o !== 1'b0) begin
            bad++;
            $display("FAIL midrst_first: got gnt=%b%b, want 01", p1_gnt_o, p0_gnt_o);
        end
        push_exp(1'b0, 1'b0, 32'h108, 4'hF, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (p1_gnt_o !== 1'b1 || p0_gnt_o !== 1'b0) begin
            bad++;
            $display("FAIL midrst_second: got gnt=%b%b, want 10", p1_gnt_o, p0_gnt_o);
        end
        push_exp(1'b1, 1'b0, 32'h10C, 4'hF, 32'h0);
        @(posedge clk); #1;
        set_p0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_p1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = (32'(i) * 32'h0103_0507) ^ 32'hA5A5_A5A5;
            shadow[i] = (32'(i) * 32'h0103_0507) ^ 32'hA5A5_A5A5;
        end
        mem[10'h040]    = 32'h4433_2211;
        shadow[10'h040] = 32'h4433_2211;
        set_p0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_p1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        test_reset();
        test_single_read();
        test_byte_write();
        test_contention();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_op();
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending responses, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
